// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for fetch_redirect_ctrl: data width, FSM encoding,
// default reset/trap vectors and an alignment helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [`DATA_WIDTH-1:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [`DATA_WIDTH-1:0] DEF_TRAP_VECTOR = 32'h0000_0100;
  localparam logic [`DATA_WIDTH-1:0] PC_STEP         = 32'h0000_0004;
  localparam logic [`DATA_WIDTH-1:0] ALIGN_MASK      = 32'hFFFF_FFFC;

  function automatic logic [`DATA_WIDTH-1:0] word_align(input logic [`DATA_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_pc_next_sel.sv
// Next fetch PC selection: redirect target (or trap vector), sequential
// increment, or hold, in that priority order.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pc_next_sel
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [`DATA_WIDTH-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic [`DATA_WIDTH-1:0] pc,
  input  logic [`DATA_WIDTH-1:0] target,
  input  logic                   redirect,
  input  logic                   trap,
  input  logic                   advance,
  output logic [`DATA_WIDTH-1:0] pc_next
);

  // Priority mux; the increment wraps naturally at the top of the address space.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      if (trap) begin
        pc_next = TRAP_VECTOR;
      end else begin
        pc_next = target;
      end
    end else if (advance) begin
      pc_next = pc + PC_STEP;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: single-outstanding imem handshake, branch redirect, pipeline
// flushes and stale-response drain. Optional macro: BRANCH_MISALIGN_CHECK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [`DATA_WIDTH-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   branch_res,
  input  logic [`DATA_WIDTH-1:0] branch_target,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [`DATA_WIDTH-1:0] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [`DATA_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [`DATA_WIDTH-1:0] if_pc,
  output logic [`DATA_WIDTH-1:0] if_instr,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   misalign_exc,
  output logic [`DATA_WIDTH-1:0] misalign_addr
);

  fetch_state_e           state_r;
  fetch_state_e           state_nxt_s;
  logic [`DATA_WIDTH-1:0] pc_r;
  logic [`DATA_WIDTH-1:0] pc_nxt_s;
  logic [`DATA_WIDTH-1:0] req_pc_r;
  logic [`DATA_WIDTH-1:0] target_s;
  logic                   outstanding_r;
  logic                   outstanding_nxt_s;
  logic                   imem_req_s;
  logic                   redirect_s;
  logic                   gnt_s;
  logic                   rsp_s;
  logic                   deliver_s;
  logic                   trap_s;

`ifdef BRANCH_MISALIGN_CHECK_EN
  logic                   misalign_exc_r;
  logic [`DATA_WIDTH-1:0] misalign_addr_r;

  assign target_s = branch_target;
  assign trap_s   = redirect_s & (branch_target[1:0] != 2'b00);

  // Exception pulse one cycle after a misaligned redirect; address sticks until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_exc_r  <= 1'b0;
      misalign_addr_r <= {`DATA_WIDTH{1'b0}};
    end else begin
      misalign_exc_r <= trap_s;
      if (trap_s) begin
        misalign_addr_r <= branch_target;
      end else begin
        misalign_addr_r <= misalign_addr_r;
      end
    end
  end

  assign misalign_exc  = misalign_exc_r;
  assign misalign_addr = misalign_addr_r;
`else
  assign target_s      = word_align(branch_target);
  assign trap_s        = 1'b0;
  assign misalign_exc  = 1'b0;
  assign misalign_addr = {`DATA_WIDTH{1'b0}};
`endif

  // Per-state handshake decode; redirects are ignored in the post-reset IDLE cycle.
  always_comb begin
    imem_req_s = 1'b0;
    redirect_s = 1'b0;
    deliver_s  = 1'b0;
    rsp_s      = imem_rvalid & outstanding_r;
    case (state_r)
      ST_IDLE: begin
        imem_req_s = 1'b0;
        redirect_s = 1'b0;
      end
      ST_RUN: begin
        imem_req_s = ~outstanding_r & ~stall;
        redirect_s = ex_valid & branch_res;
        deliver_s  = rsp_s & ~redirect_s;
      end
      ST_DRAIN: begin
        redirect_s = ex_valid & branch_res;
      end
      default: begin
        imem_req_s = 1'b0;
        redirect_s = 1'b0;
      end
    endcase
  end

  assign gnt_s = imem_req_s & imem_gnt;

  // A grant in the same cycle as a response leaves the new request outstanding.
  always_comb begin
    if (gnt_s) begin
      outstanding_nxt_s = 1'b1;
    end else if (rsp_s) begin
      outstanding_nxt_s = 1'b0;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
  end

  // DRAIN is needed only when a request will still be in flight after the redirect.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (redirect_s && outstanding_nxt_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (rsp_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  pc_next_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_pc_next_sel (
    .pc      (pc_r),
    .target  (target_s),
    .redirect(redirect_s),
    .trap    (trap_s),
    .advance (gnt_s),
    .pc_next (pc_nxt_s)
  );

  // State, PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      req_pc_r      <= {`DATA_WIDTH{1'b0}};
      outstanding_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      if (gnt_s) begin
        req_pc_r <= pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
    end
  end

  assign imem_req    = imem_req_s;
  assign imem_addr   = pc_r;
  assign if_valid    = deliver_s;
  assign if_pc       = deliver_s ? req_pc_r : {`DATA_WIDTH{1'b0}};
  assign if_instr    = deliver_s ? imem_rdata : {`DATA_WIDTH{1'b0}};
  assign flush_if_id = redirect_s;
  assign flush_id_ex = redirect_s;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus random
// stimulus against a queue-based reference model of in-flight fetches.
module tb_fetch_redirect_ctrl;

`ifdef BRANCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, branch_res, stall;
  logic [31:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, flush_if_id, flush_id_ex, misalign_exc;
  logic [31:0] if_pc, if_instr, misalign_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        stale;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_exc;
  logic [31:0] m_maddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .branch_res   (branch_res),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 32'h0000_0000;
    m_started = 1'b0;
    m_exc     = 1'b0;
    m_maddr   = 32'h0000_0000;
  endtask

  // Assert reset away from the clock edge, check reset values, release after a posedge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    ex_valid      = 1'b0;
    branch_res    = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    #1;
    chk("rst_imem_req", imem_req, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", if_valid, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_flush_if_id", flush_if_id, 32'd0);
    chk("rst_flush_id_ex", flush_id_ex, 32'd0);
    chk("rst_misalign_exc", misalign_exc, 32'd0);
    chk("rst_misalign_addr", misalign_addr, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic ev, input logic br, input logic [31:0] tgt,
                      input logic st, input logic g, input logic rv);
    logic        redir, exp_req, rsp, exp_val, mis;
    logic [31:0] rd, exp_pc;
    @(negedge clk);
    rd            = $urandom();
    ex_valid      = ev;
    branch_res    = br;
    branch_target = tgt;
    stall         = st;
    imem_gnt      = g;
    imem_rvalid   = rv;
    imem_rdata    = rd;
    #2;
    redir   = m_started && ev && br;
    exp_req = m_started && (m_q.size() == 0) && !st;
    rsp     = rv && (m_q.size() != 0);
    exp_val = rsp && !m_q[0].stale && !redir;
    exp_pc  = exp_val ? m_q[0].pc : 32'h0;
    mis     = MIS_EN && (tgt[1:0] != 2'b00);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, exp_val);
    chk("if_pc", if_pc, exp_pc);
    chk("if_instr", if_instr, exp_val ? rd : 32'h0);
    chk("flush_if_id", flush_if_id, redir);
    chk("flush_id_ex", flush_id_ex, redir);
    chk("misalign_exc", misalign_exc, m_exc);
    chk("misalign_addr", misalign_addr, m_maddr);
    if (rsp) void'(m_q.pop_front());
    if (redir) begin
      foreach (m_q[i]) m_q[i].stale = 1'b1;
    end
    if (exp_req && g) m_q.push_back('{m_pc, redir});
    if (redir) m_pc = mis ? TRAP : (tgt & 32'hFFFF_FFFC);
    else if (exp_req && g) m_pc = m_pc + 32'd4;
    m_exc = redir && mis;
    if (redir && mis) m_maddr = tgt;
    m_started = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    rst_n = 1'b0;
    model_reset();
    do_reset();

    // Sequential fetch with gnt and rvalid held high.
    step(0, 0, 32'h0, 0, 1, 1); chk("idle_req", imem_req, 32'd0);
    step(0, 0, 32'h0, 0, 1, 1); chk("c2_req", imem_req, 32'd1); chk("c2_addr", imem_addr, 32'h0);
    step(0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 32'h0, 0, 1, 1); chk("addr_4", imem_addr, 32'h4);
    step(0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 32'h0, 0, 1, 1); chk("addr_8", imem_addr, 32'h8);
    repeat (3) step(0, 0, 32'h0, 0, 1, 1);

    // Stall at pc 0x10.
    repeat (3) begin
      step(0, 0, 32'h0, 1, 1, 1); chk("stall_req", imem_req, 32'd0);
    end
    step(0, 0, 32'h0, 0, 1, 0); chk("resume_addr", imem_addr, 32'h10);
    step(0, 0, 32'h0, 0, 0, 1); chk("resume_if_pc", if_pc, 32'h10);

    // Redirect to 0x200 while 0x14 is outstanding.
    step(0, 0, 32'h0, 0, 1, 0);
    step(1, 1, 32'h200, 0, 1, 0); chk("redir_flush", flush_if_id, 32'd1);
    step(0, 0, 32'h0, 0, 1, 1); chk("stale_drop", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 1, 0); chk("target_addr", imem_addr, 32'h200);
    step(0, 0, 32'h0, 0, 0, 1); chk("target_if_pc", if_pc, 32'h200);

    // Redirect coinciding with rvalid and gnt.
    step(1, 1, 32'h300, 0, 1, 1); chk("coinc_drop", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 1, 1); chk("coinc_stale", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 1, 0); chk("coinc_addr", imem_addr, 32'h300);
    step(0, 0, 32'h0, 0, 0, 1); chk("coinc_if_pc", if_pc, 32'h300);

    // Misaligned target.
    step(1, 1, 32'h202, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    chk("mis_addr", imem_addr, MIS_EN ? 32'h100 : 32'h200);
`ifdef BRANCH_MISALIGN_CHECK_EN
    chk("mis_exc_pulse", misalign_exc, 32'd1);
    chk("mis_exc_addr", misalign_addr, 32'h202);
`endif
    step(0, 0, 32'h0, 0, 0, 0);
    chk("mis_exc_end", misalign_exc, 32'd0);

    // Wrap at the top of the address space.
    step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 0); chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 0); chk("wrap_zero", imem_addr, 32'h0);

    // Reset in the middle of DRAIN, then ignore rvalid before the first grant.
    step(0, 0, 32'h0, 0, 1, 0);
    step(1, 1, 32'h400, 0, 0, 0);
    do_reset();
    step(0, 0, 32'h0, 0, 0, 1); chk("post_rst_idle", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 0, 1); chk("post_rst_nognt", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 1, 1); chk("post_rst_gnt", if_valid, 32'd0);
    step(0, 0, 32'h0, 0, 0, 1); chk("post_rst_first", if_pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      t = $urandom();
      if ($urandom_range(0, 9) == 0) t[31:16] = 16'hFFFF;
      else t[31:16] = 16'h0000;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, t,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

- Owns the fetch PC and the instruction-memory request port.
- Consumes the taken/not-taken result from branch resolution in EX and redirects fetch to the branch target.
- Generates the flushes for IF/ID and ID/EX.
- Discards stale instruction responses still in flight when a redirect occurs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, redirect address for a misaligned target (used only under the macro)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- branch_res  in  1  branch/jal taken, qualified by ex_valid
- branch_target  in  `DATA_WIDTH  redirect address
- stall  in  1  hazard stall; no new fetch issue while high
- imem_req  out  1  fetch request
- imem_addr  out  `DATA_WIDTH  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  `DATA_WIDTH  instruction word
- if_valid  out  1  instruction delivered to IF/ID
- if_pc  out  `DATA_WIDTH  PC of the delivered instruction
- if_instr  out  `DATA_WIDTH  delivered instruction
- flush_if_id  out  1  kill IF/ID contents at the next edge
- flush_id_ex  out  1  kill ID/EX contents at the next edge
- misalign_exc  out  1  one-cycle pulse (macro only)
- misalign_addr  out  `DATA_WIDTH  offending target (macro only)

## Operation
- redirect = ex_valid & branch_res.
- Registers:
  - pc: next address to request
  - req_pc: address of the outstanding request
  - outstanding: 1 bit
  - state
- At most one outstanding request.
- States:
  - IDLE: the single cycle after reset; imem_req=0; goes to RUN.
  - RUN:
    - imem_req = ~outstanding & ~stall, with imem_addr=pc.
    - On gnt: req_pc<=pc, pc<=pc+4 (wraps modulo 2^32), outstanding<=1.
    - On rvalid: if_valid=1, if_pc=req_pc, if_instr=imem_rdata, outstanding<=0.
    - rvalid and a new gnt in the same cycle are legal.
  - DRAIN: entered on a redirect while a request is outstanding, or is granted in the same cycle.
    - imem_req=0.
    - The next rvalid is dropped (if_valid=0), then the state goes to RUN.
- Redirect, in any state except IDLE:
  - pc<=target; the combinational increment is discarded.
  - flush_if_id=flush_id_ex=1, combinationally, in the same cycle.
  - if_valid forced 0 that cycle, even with rvalid.
  - Goes to DRAIN if outstanding, or if gnt occurs in the same cycle; otherwise stays in RUN.
  - Redirect in DRAIN updates pc and stays in DRAIN; exactly one stale response is still owed.
- Priority: redirect > stall > sequential increment.
- An ungranted imem_req may change address only on a redirect; otherwise imem_addr is held stable until gnt.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, flushes=0, misalign_exc=0, misalign_addr=0, pc=RESET_PC, state=IDLE.
- First imem_req is asserted in the second cycle after rst_n deasserts.
- Redirect in cycle N with nothing outstanding: imem_req with target at N+1.
- Redirect with a stale response outstanding: imem_req with target in the cycle after the stale rvalid.
- if_* outputs are combinational from rvalid (zero added latency).
- Reset asserted mid-transaction: all state clears immediately. An imem_rvalid arriving before the first post-reset gnt is ignored.

## Configuration
- Macro: BRANCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with branch_target[1:0]!=0 sets pc<=TRAP_VECTOR instead of the target.
  - Flushes still assert.
  - misalign_exc pulses one cycle later (registered), with misalign_addr=branch_target, held until the next misaligned redirect.
- Undefined:
  - branch_target[1:0] is forced to 2'b00.
  - misalign_exc and misalign_addr are tied to 0.

## Structure
- Shared package/include.v: `DATA_WIDTH, state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), the default RESET_PC/TRAP_VECTOR constants.
- One sub-module: pc_next_sel. It is combinational and selects target/TRAP_VECTOR/pc+4/pc by priority.
- State machine and handshake tracking stay in the top module.

## Test plan
- Reset release, gnt and rvalid every cycle:
  - Required: first imem_addr=0x0 in cycle 2, then 0x4 and 0x8.
  - Required: if_pc matches each delivered instruction.
- stall=1 for 3 cycles at pc=0x10:
  - Required: imem_req=0 throughout.
  - Required: the fetch resumes at 0x10 with no skip or duplicate.
- Redirect to 0x200 with a request to 0x14 outstanding:
  - Required: flushes asserted the same cycle.
  - Required: the 0x14 response is dropped (if_valid=0).
  - Required: the next imem_addr=0x200.
- Redirect coinciding with rvalid and gnt in one cycle:
  - Required: that instruction is dropped.
  - Required: exactly one later response is dropped.
  - Required: the first delivered if_pc equals the target.
- With BRANCH_MISALIGN_CHECK_EN, redirect to 0x202:
  - Required: next imem_addr=0x100.
  - Required: misalign_exc pulses one cycle later, with misalign_addr=0x202.
- Wrap: sequential fetch at 0xFFFF_FFFC, then the next address is 0x0000_0000. Also assert rst_n low mid-DRAIN, then check all reset values.
